vga_fb_window_reader: RTL and testbench

- Parametrised successor to the fixed 2x QVGA frame-buffer reader.
- Reads an SRC_W x SRC_H RGB565 frame buffer with a runtime-selectable integer upscale (1x/2x/4x), placed at a runtime window origin on the H_ACTIVE x V_ACTIVE raster.
- Outside the window it drives a programmable border colour; outside DE it drives black.
- Addresses come from incremental counters (no multiplier). Configuration is double-buffered and applied only at frame start. Sits between the VGA timing generator and the frame-buffer BRAM read port.

---
 rtl/vga_fb_pkg.sv | 46 ++++
 rtl/vga_fb_addr_gen.sv | 114 +++++++++++
 rtl/vga_fb_window_reader.sv | 129 ++++++++++++
 tb/tb_vga_fb_window_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the frame-buffer window reader.
package vga_fb_pkg;

  typedef enum logic [1:0] {
    SCALE_1X = 2'd0,
    SCALE_2X = 2'd1,
    SCALE_4X = 2'd2
  } scale_e;

  typedef struct packed {
    scale_e      scale;
    logic [9:0]  win_x;
    logic [9:0]  win_y;
    logic [11:0] border;
  } cfg_t;

  typedef struct packed {
    logic de;
    logic valid;
    logic win;
  } pix_cls_t;

  // RGB565 field MSBs; each field is cut down to its top 4 bits.
  localparam int unsigned RMsb = 15;
  localparam int unsigned GMsb = 10;
  localparam int unsigned BMsb = 4;

  localparam cfg_t CfgReset = '{scale: SCALE_2X, win_x: 10'd0, win_y: 10'd0, border: 12'd0};

  function automatic scale_e decode_scale(logic [1:0] raw);
    case (raw)
      2'd1:    return SCALE_2X;
      2'd2:    return SCALE_4X;
      default: return SCALE_1X;
    endcase
  endfunction

  function automatic logic [1:0] scale_shift(scale_e s);
    case (s)
      SCALE_2X: return 2'd1;
      SCALE_4X: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Window test and incremental source-address counters (no multiplier).
module vga_fb_addr_gen
  import vga_fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SRC_W    = 320,
  parameter int unsigned SRC_H    = 240,
  parameter int unsigned ADDR_W   = $clog2(SRC_W * SRC_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              de_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  input  logic              frame_start_i,
  input  scale_e            scale_i,
  input  logic [9:0]        win_x_i,
  input  logic [9:0]        win_y_i,
  output logic              in_window_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int unsigned SrcN = SRC_W * SRC_H;
  localparam int unsigned SxW  = $clog2(SRC_W + 1);
  localparam int unsigned RbW  = $clog2(SrcN + 1);

  logic [1:0]        sh, smax;
  logic [11:0]       x_w, y_w, wx, wy, x_end, y_end;
  logic              in_x, in_y, row_start, valid_eff;
  logic [SxW-1:0]    src_x_q, src_x_d, cur_src_x;
  logic [1:0]        hsub_q, hsub_d, cur_hsub, vsub_q, vsub_d, cur_vsub;
  logic [RbW-1:0]    row_base_q, row_base_d, cur_rb;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign sh    = scale_shift(scale_i);
  assign smax  = 2'((3'd1 << sh) - 3'd1);
  assign x_w   = {2'b00, x_i};
  assign y_w   = {2'b00, y_i};
  assign wx    = {2'b00, win_x_i};
  assign wy    = {2'b00, win_y_i};
  assign x_end = wx + (12'(SRC_W) << sh);
  assign y_end = wy + (12'(SRC_H) << sh);

  assign in_x = (x_w >= wx) && (x_w < x_end) && (x_w < 12'(H_ACTIVE));
  assign in_y = (y_w >= wy) && (y_w < y_end) && (y_w < 12'(V_ACTIVE));

  // Counters are meaningless between a reset and the next frame start.
  assign valid_eff = valid_q || frame_start_i;
  assign row_start = (x_w == wx);
  assign cur_src_x = row_start ? '0 : src_x_q;
  assign cur_hsub  = row_start ? '0 : hsub_q;
  assign cur_rb    = frame_start_i ? '0 : row_base_q;
  assign cur_vsub  = frame_start_i ? '0 : vsub_q;

  // A counter that ran past its limit marks the pixel out-of-window.
  assign in_window_o = valid_eff && de_i && in_x && in_y &&
                       (cur_src_x < SxW'(SRC_W)) && (cur_rb < RbW'(SrcN));
  assign valid_o = valid_eff;
  assign addr_o  = addr_q;

  always_comb begin
    src_x_d    = src_x_q;
    hsub_d     = hsub_q;
    row_base_d = row_base_q;
    vsub_d     = vsub_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    if (frame_start_i) begin
      row_base_d = '0;
      vsub_d     = '0;
      valid_d    = 1'b1;
    end
    if (in_window_o) begin
      addr_d = ADDR_W'(cur_rb + RbW'(cur_src_x));
      if (cur_hsub == smax) begin
        hsub_d  = '0;
        src_x_d = cur_src_x + 1'b1;
      end else begin
        hsub_d  = cur_hsub + 2'd1;
        src_x_d = cur_src_x;
      end
    end
    if (de_i && in_y && (x_w == 12'(H_ACTIVE - 1))) begin
      if (cur_vsub == smax) begin
        vsub_d = '0;
        if (cur_rb < RbW'(SrcN)) row_base_d = cur_rb + RbW'(SRC_W);
      end else begin
        vsub_d = cur_vsub + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_x_q    <= '0;
      hsub_q     <= '0;
      row_base_q <= '0;
      vsub_q     <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
    end else begin
      src_x_q    <= src_x_d;
      hsub_q     <= hsub_d;
      row_base_q <= row_base_d;
      vsub_q     <= vsub_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: rtl/vga_fb_window_reader.sv
// Scaled, windowed RGB565 frame-buffer reader between VGA timing and the BRAM read port.
module vga_fb_window_reader
  import vga_fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SRC_W    = 320,
  parameter int unsigned SRC_H    = 240,
  parameter int unsigned ADDR_W   = $clog2(SRC_W * SRC_H),
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DE,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic [1:0]        cfg_scale,
  input  logic [9:0]        cfg_win_x,
  input  logic [9:0]        cfg_win_y,
  input  logic [11:0]       cfg_border,
  input  logic              cfg_update,
  output logic              cfg_pending,
  output logic [ADDR_W-1:0] addr,
  input  logic [15:0]       imgData,
  output logic [3:0]        r_port,
  output logic [3:0]        g_port,
  output logic [3:0]        b_port,
  output logic              de_out,
  output logic              frame_start
);

  cfg_t        shadow_q, shadow_d, active_q, active_d, cfg_in, cfg_eff;
  logic        pending_q, pending_d, fs_now, fs_q;
  logic        in_win, pix_valid;
  pix_cls_t    cls_now, cls_out;
  pix_cls_t    cls_q [MEM_LAT+1];
  logic [11:0] rgb_q, rgb_d;
  logic        de_out_q;
  logic        unused_img_bits;

  assign fs_now = DE && (x_pixel == 10'd0) && (y_pixel == 10'd0);
  assign cfg_in = '{scale: decode_scale(cfg_scale), win_x: cfg_win_x,
                    win_y: cfg_win_y, border: cfg_border};
  // The frame-start pixel itself is mapped with the config being loaded.
  assign cfg_eff = fs_now ? shadow_q : active_q;

  always_comb begin
    shadow_d  = cfg_update ? cfg_in : shadow_q;
    active_d  = fs_now ? shadow_q : active_q;
    pending_d = cfg_update || (pending_q && !fs_now);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q  <= CfgReset;
      active_q  <= CfgReset;
      pending_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      fs_q      <= fs_now;
    end
  end

  vga_fb_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .SRC_W    (SRC_W),
    .SRC_H    (SRC_H),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk           (clk),
    .reset         (reset),
    .de_i          (DE),
    .x_i           (x_pixel),
    .y_i           (y_pixel),
    .frame_start_i (fs_now),
    .scale_i       (cfg_eff.scale),
    .win_x_i       (cfg_eff.win_x),
    .win_y_i       (cfg_eff.win_y),
    .in_window_o   (in_win),
    .valid_o       (pix_valid),
    .addr_o        (addr)
  );

  assign cls_now = '{de: DE, valid: pix_valid, win: in_win};
  assign cls_out = cls_q[MEM_LAT];

  // Stage 0 lines up with addr; stage MEM_LAT lines up with imgData.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i <= MEM_LAT; i++) cls_q[i] <= '0;
    end else begin
      cls_q[0] <= cls_now;
      for (int unsigned i = 1; i <= MEM_LAT; i++) cls_q[i] <= cls_q[i-1];
    end
  end

  // Border reads the live active config; a frame switch only happens after blanking.
  always_comb begin
    rgb_d = 12'h000;
    if (cls_out.de && cls_out.valid) begin
      if (cls_out.win) rgb_d = {imgData[RMsb -: 4], imgData[GMsb -: 4], imgData[BMsb -: 4]};
      else             rgb_d = active_q.border;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q    <= 12'h000;
      de_out_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      de_out_q <= cls_out.de;
    end
  end

  assign unused_img_bits = ^{imgData[11], imgData[5], imgData[0]};

  assign r_port      = rgb_q[11:8];
  assign g_port      = rgb_q[7:4];
  assign b_port      = rgb_q[3:0];
  assign de_out      = de_out_q;
  assign cfg_pending = pending_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_fb_window_reader.sv
// Directed bench: a MEM_LAT=1 and a MEM_LAT=3 reader driven with sparse raster sequences.
module tb_vga_fb_window_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, de, cfg_update;
  logic [9:0]  x_px, y_px, cfg_win_x, cfg_win_y;
  logic [1:0]  cfg_scale;
  logic [11:0] cfg_border;
  logic [15:0] img0, img1;

  logic        pend0, deo0, fs0, pend1, deo1, fs1;
  logic [16:0] addr0, addr1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic [11:0] rgb0, rgb1;

  int n_tests = 0;
  int n_fail  = 0;
  int fs_cnt  = 0;

  assign rgb0 = {r0, g0, b0};
  assign rgb1 = {r1, g1, b1};
  assign img1 = 16'hFFFF;

  // Frame-buffer model with one clock of read latency; word = ~address.
  always_ff @(posedge clk) img0 <= 16'hFFFF ^ 16'(addr0);

  vga_fb_window_reader u_dut0 (
    .clk (clk), .reset (reset), .DE (de), .x_pixel (x_px), .y_pixel (y_px),
    .cfg_scale (cfg_scale), .cfg_win_x (cfg_win_x), .cfg_win_y (cfg_win_y),
    .cfg_border (cfg_border), .cfg_update (cfg_update), .cfg_pending (pend0),
    .addr (addr0), .imgData (img0), .r_port (r0), .g_port (g0), .b_port (b0),
    .de_out (deo0), .frame_start (fs0)
  );

  vga_fb_window_reader #(.MEM_LAT (3)) u_dut1 (
    .clk (clk), .reset (reset), .DE (de), .x_pixel (x_px), .y_pixel (y_px),
    .cfg_scale (cfg_scale), .cfg_win_x (cfg_win_x), .cfg_win_y (cfg_win_y),
    .cfg_border (cfg_border), .cfg_update (cfg_update), .cfg_pending (pend1),
    .addr (addr1), .imgData (img1), .r_port (r1), .g_port (g1), .b_port (b1),
    .de_out (deo1), .frame_start (fs1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pix(input logic d, input int x, input int y);
    de   = d;
    x_px = 10'(x);
    y_px = 10'(y);
    @(posedge clk);
    #1;
    if (fs0) fs_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      de = 1'b0;
      @(posedge clk);
      #1;
      if (fs0) fs_cnt++;
    end
  endtask

  task automatic set_cfg(input logic [1:0] s, input int wx, input int wy, input logic [11:0] bc);
    cfg_scale  = s;
    cfg_win_x  = 10'(wx);
    cfg_win_y  = 10'(wy);
    cfg_border = bc;
  endtask

  initial begin
    reset = 1'b1; de = 1'b0; x_px = '0; y_px = '0; cfg_update = 1'b0;
    set_cfg(2'd0, 0, 0, 12'h000);
    idle(3);
    check_val("rst_addr", 32'(addr0), 32'd0);
    check_val("rst_rgb_de", 32'({rgb0, deo0}), 32'd0);
    check_val("rst_pend_fs", 32'({pend0, fs0}), 32'd0);
    check_val("rst_dut1", {addr1, rgb1, deo1, pend1, fs1}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Frame A: reset config (2x at 0,0), plus latency checks on both builds.
    pix(1'b1, 0, 0);
    check_val("a_fs", 32'(fs0), 32'd1);
    check_val("a_addr_0_0", 32'(addr0), 32'd0);
    idle(1);
    check_val("a_rgb_early", 32'({rgb0, deo0}), 32'd0);
    check_val("a_fs_clear", 32'(fs0), 32'd0);
    idle(1);
    check_val("a_rgb_lat3", 32'({rgb0, deo0}), 32'h1FFF);
    idle(1);
    check_val("l3_rgb_early", 32'({rgb1, deo1}), 32'd0);
    idle(1);
    check_val("l3_rgb_lat5", 32'({rgb1, deo1}), 32'h1FFF);
    idle(1);
    check_val("l3_de_low_black", 32'({rgb1, deo1}), 32'd0);
    for (int x = 1; x < 640; x++) begin
      pix(1'b1, x, 0);
      check_val("a_row0", 32'(addr0), 32'(x / 2));
    end
    set_cfg(2'd0, 100, 50, 12'hF00);
    cfg_update = 1'b1;
    pix(1'b1, 639, 1);
    cfg_update = 1'b0;
    check_val("a_pending", 32'(pend0), 32'd1);
    pix(1'b1, 0, 2);
    check_val("a_row2_x0", 32'(addr0), 32'd320);
    pix(1'b1, 1, 2);
    check_val("a_row2_x1", 32'(addr0), 32'd320);
    pix(1'b1, 2, 2);
    check_val("a_row2_x2", 32'(addr0), 32'd321);
    pix(1'b1, 639, 2);
    for (int y = 3; y < 479; y++) pix(1'b1, 639, y);
    for (int x = 0; x < 640; x++) begin
      pix(1'b1, x, 479);
      if (x == 0)   check_val("a_row479_x0", 32'(addr0), 32'd76480);
      if (x == 639) check_val("a_last_pixel", 32'(addr0), 32'd76799);
    end
    check_val("a_pend_hold", 32'(pend0), 32'd1);
    idle(8);

    // Frame B: 1x, window (100,50), border F00.
    fs_cnt = 0;
    pix(1'b1, 0, 0);
    check_val("b_fs", 32'(fs0), 32'd1);
    check_val("b_pend_clear", 32'(pend0), 32'd0);
    pix(1'b1, 99, 50);
    idle(2);
    check_val("b_border_left", 32'(rgb0), 32'hF00);
    pix(1'b1, 100, 50);
    check_val("b_addr_first", 32'(addr0), 32'd0);
    for (int x = 101; x < 420; x++) pix(1'b1, x, 50);
    check_val("b_addr_last", 32'(addr0), 32'd319);
    idle(2);
    check_val("b_rgb_419", 32'(rgb0), 32'hFD0);
    pix(1'b1, 420, 50);
    check_val("b_addr_hold", 32'(addr0), 32'd319);
    idle(2);
    check_val("b_border_right", 32'(rgb0), 32'hF00);
    pix(1'b1, 639, 50);
    pix(1'b1, 100, 51);
    check_val("b_row51", 32'(addr0), 32'd320);
    pix(1'b1, 639, 51);
    for (int y = 52; y < 290; y++) pix(1'b1, 639, y);
    pix(1'b1, 100, 290);
    check_val("b_addr_row290", 32'(addr0), 32'd320);
    idle(2);
    check_val("b_border_below", 32'(rgb0), 32'hF00);
    idle(4);
    check_val("b_fs_count", 32'(fs_cnt), 32'd1);
    set_cfg(2'd2, 0, 0, 12'h000);
    cfg_update = 1'b1;
    idle(1);
    cfg_update = 1'b0;
    check_val("b_pend_4x", 32'(pend0), 32'd1);
    idle(4);

    // Frame C: 4x; an update on the frame-start cycle stays pending.
    set_cfg(2'd0, 0, 0, 12'h0F0);
    cfg_update = 1'b1;
    pix(1'b1, 0, 0);
    cfg_update = 1'b0;
    check_val("c_fs", 32'(fs0), 32'd1);
    check_val("c_pend_same_cycle", 32'(pend0), 32'd1);
    check_val("c_addr_0_0", 32'(addr0), 32'd0);
    for (int x = 1; x < 5; x++) begin
      pix(1'b1, x, 0);
      check_val("c_row0", 32'(addr0), 32'(x / 4));
    end
    pix(1'b1, 639, 0);
    for (int y = 1; y < 4; y++) pix(1'b1, 639, y);
    pix(1'b1, 0, 4);
    check_val("c_row4", 32'(addr0), 32'd320);
    pix(1'b1, 639, 4);
    for (int y = 5; y < 479; y++) pix(1'b1, 639, y);
    for (int x = 0; x < 640; x++) begin
      pix(1'b1, x, 479);
      if (x == 639) check_val("c_last_pixel", 32'(addr0), 32'd38239);
    end
    idle(8);

    // Frame D: pending 1x (0,0) border 0F0 applies, then reset mid-frame.
    pix(1'b1, 0, 0);
    check_val("d_fs", 32'(fs0), 32'd1);
    check_val("d_pend_clear", 32'(pend0), 32'd0);
    pix(1'b1, 320, 0);
    idle(2);
    check_val("d_border_1x", 32'(rgb0), 32'h0F0);
    for (int y = 0; y < 100; y++) pix(1'b1, 639, y);
    reset = 1'b1;
    pix(1'b1, 200, 100);
    reset = 1'b0;
    check_val("r_addr", 32'(addr0), 32'd0);
    check_val("r_rgb_de", 32'({rgb0, deo0}), 32'd0);
    check_val("r_pend_fs", 32'({pend0, fs0}), 32'd0);
    for (int x = 201; x < 211; x++) begin
      pix(1'b1, x, 100);
      check_val("r_black", 32'(rgb0), 32'd0);
    end
    idle(3);
    check_val("r_addr_hold", 32'(addr0), 32'd0);
    idle(8);

    // Frame E: reset config is back in force.
    pix(1'b1, 0, 0);
    check_val("e_fs", 32'(fs0), 32'd1);
    check_val("e_addr_0_0", 32'(addr0), 32'd0);
    for (int x = 1; x < 4; x++) begin
      pix(1'b1, x, 0);
      check_val("e_row0", 32'(addr0), 32'(x / 2));
    end
    pix(1'b1, 639, 0);
    pix(1'b1, 639, 1);
    pix(1'b1, 0, 2);
    check_val("e_row2", 32'(addr0), 32'd320);
    check_val("e_row2_dut1", 32'(addr1), 32'd320);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
